// File: rtl/md_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation encodings, FSM states, iteration count and a wide negate helper.
package md_pkg;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return (~v) + 64'd1;
  endfunction

endpackage

// File: rtl/md_abs32.sv
// Conditional two's-complement negation; used both to take operand magnitudes
// and to restore the sign of a divide result.
module md_abs32
  import md_pkg::*;
(
  input  logic [31:0] val,
  input  logic        neg,
  output logic [31:0] res
);

  assign res = neg ? ((~val) + 32'd1) : val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle, fixed 33-cycle latency from the accepting edge to DONE.
module mul_div_unit
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] y
);

  state_e      state, state_next;
  op_e         op_in, op_q;
  logic [63:0] acc;
  logic [31:0] opb;
  logic [5:0]  cnt;
  logic        neg_res;

  logic        a_signed, b_signed, sa, sb, neg_next;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [33:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] prod;
  logic [31:0] div_raw, div_fixed;
  logic [31:0] result;

  assign op_in    = op_e'(op);
  assign a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
  assign b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
  assign sa       = a_signed & a[31];
  assign sb       = b_signed & b[31];

  // A zero divisor yields an all-ones quotient magnitude that must stay unsigned,
  // and the remainder always takes the dividend's sign.
  always_comb begin
    neg_next = 1'b0;
    if (!op_in[2])
      neg_next = sa ^ sb;
    else if (op_in[1])
      neg_next = sa;
    else
      neg_next = (sa ^ sb) & (b != 32'd0);
  end

  md_abs32 u_abs_a (.val(a), .neg(sa), .res(mag_a));
  md_abs32 u_abs_b (.val(b), .neg(sb), .res(mag_b));

  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mul_step = {mul_sum, acc[31:1]};

  assign div_diff = {1'b0, acc[63:31]} - {2'b00, opb};
  assign div_step = div_diff[33] ? {acc[62:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

  assign prod    = neg_res ? neg64(acc) : acc;
  assign div_raw = op_q[1] ? acc[63:32] : acc[31:0];

  md_abs32 u_abs_res (.val(div_raw), .neg(neg_res), .res(div_fixed));

  always_comb begin
    result = div_fixed;
    if (!op_q[2])
      result = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: the counter reaching the last iteration ends CALC.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  if (cnt == 6'(ITER - 1)) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Datapath: operands are captured only on acceptance, so requests arriving
  // mid-operation cannot disturb the computation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= 64'd0;
      opb     <= 32'd0;
      cnt     <= 6'd0;
      op_q    <= OP_MUL;
      neg_res <= 1'b0;
      y       <= 32'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_in;
            cnt     <= 6'd0;
            neg_res <= neg_next;
            if (op_in[2]) begin
              acc <= {32'd0, mag_a};
              opb <= mag_b;
            end else begin
              acc <= {32'd0, mag_b};
              opb <= mag_a;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + 6'd1;
          acc <= op_q[2] ? div_step : mul_step;
        end
        S_FIN: begin
          y    <= result;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed results,
// latency, BUSY window, result hold, ignored START and abort-by-reset checks.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] prevY = 32'd0;
  int lat, busyCnt, yChg, doneSeen;

  mul_div_unit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Raises START for exactly one rising edge; returns #1 after that edge.
  task automatic driveStart(input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] z);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = z;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] z);
    @(negedge clk);
    driveStart(o, x, z);
  endtask

  // Counts cycles until DONE, bounded at 40; tallies BUSY and any Y change.
  task automatic waitDone(input logic [31:0] hold, output int l, output int bc,
                          output int yc);
    l  = 0;
    bc = 0;
    yc = 0;
    while (l < 40 && done !== 1'b1) begin
      if (busy === 1'b1) bc++;
      if (y !== hold) yc++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] z, input logic [31:0] expY);
    applyStimulus(o, x, z);
    waitDone(prevY, lat, busyCnt, yChg);
    checkOutput({tag, "_y"}, y, expY);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd33);
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'd33);
    checkOutput({tag, "_y_hold"}, 32'(yChg), 32'd0);
    checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    prevY = expY;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    op    = 3'b000;
    a     = 32'd5;
    b     = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_y", y, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;

    runOp("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    checkOutput("done_pulse_width", {31'd0, done}, 32'd0);
    checkOutput("y_hold_after_done", y, 32'hFFFF_FFEB);

    runOp("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    runOp("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    runOp("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    runOp("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    runOp("divu_m7_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    runOp("remu_m7_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001);

    runOp("divu_by0", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF);
    runOp("remu_by0", 3'b111, 32'd100, 32'd0, 32'd100);
    runOp("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    runOp("div_m7_by0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    runOp("rem_m7_by0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

    // START during cycle 5 of a busy MUL must be ignored.
    applyStimulus(3'b000, 32'd5, 32'd6);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    driveStart(3'b100, 32'd1000, 32'd3);
    waitDone(prevY, lat, busyCnt, yChg);
    checkOutput("ignored_start_y", y, 32'd30);
    checkOutput("ignored_start_latency", 32'(lat + 5), 32'd33);
    prevY = 32'd30;

    // Reset at cycle 10 of a DIV aborts it without a DONE pulse.
    applyStimulus(3'b100, 32'd1000, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_y", y, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || y !== 32'd0) doneSeen++;
    end
    checkOutput("abort_no_done_no_result", 32'(doneSeen), 32'd0);
    prevY = 32'd0;

    runOp("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12);

    // Back-to-back: second START raised in the DONE cycle of the first.
    runOp("b2b_first_divu", 3'b101, 32'd100, 32'd7, 32'd14);
    driveStart(3'b111, 32'd100, 32'd7);
    waitDone(prevY, lat, busyCnt, yChg);
    checkOutput("b2b_second_y", y, 32'd2);
    checkOutput("b2b_second_latency", 32'(lat), 32'd33);
    checkOutput("b2b_first_y_held", 32'(yChg), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 START  input  1  request strobe, sampled on the rising edge of CLK.
REQ-005 OP  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 A  input  32  rs1 operand (dividend or multiplicand).
REQ-007 B  input  32  rs2 operand (divisor or multiplier).
REQ-008 BUSY  output  1  high while an operation is in progress.
REQ-009 DONE  output  1  single-cycle pulse marking the cycle in which Y becomes valid.
REQ-010 Y  output  32  result; this feeds the write-back select mux data input D.

Function
REQ-011 State machine: IDLE -> CALC on accepted START; CALC -> FIN after 32 iterations; FIN -> IDLE unconditionally.
REQ-012 START SHALL be accepted only when the FSM is in IDLE; on acceptance, A, B and OP SHALL be latched and never re-sampled during the operation.
REQ-013 START asserted while BUSY is high SHALL be ignored, with no effect on the operation in flight.
REQ-014 Let edge k be the edge that accepts START. BUSY SHALL be high from after edge k until edge k+33.
REQ-015 The edges k+1 through k+32 SHALL each perform exactly one iteration: a shift-add step for MUL* or a restoring-divide step for DIV*/REM*.
REQ-016 Edge k+33 SHALL register Y, assert DONE for exactly one cycle, and deassert BUSY.
REQ-017 Latency SHALL be a fixed 33 cycles for every OP, special cases included.
REQ-018 Y SHALL hold its value until the next DONE, or until RST.
REQ-019 A new START SHALL be acceptable in the cycle in which DONE is high (back-to-back operation).
REQ-020 MUL SHALL return the low 32 bits of the product.
REQ-021 MULH, MULHSU and MULHU SHALL return the high 32 bits of the 64-bit product with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-022 Signed operations SHALL compute on magnitudes and negate the result at FIN when required.
REQ-023 The remainder sign SHALL follow the dividend, and the quotient SHALL truncate toward zero.
REQ-024 Divide by zero: DIV and DIVU SHALL return 0xFFFFFFFF; REM and REMU SHALL return A.
REQ-025 Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-026 All arithmetic SHALL be two's complement with no exceptions and no flags.

Reset
REQ-027 On RST, the FSM SHALL enter IDLE, and BUSY, DONE and Y SHALL all be 0 on the following cycle.
REQ-028 RST SHALL take priority over START in the same cycle.
REQ-029 RST asserted mid-operation SHALL abort the operation with no DONE pulse, and the aborted result SHALL never appear on Y.

Structure
REQ-030 The OP encodings and the FSM state encoding SHALL be defined in a shared package, md_pkg.
REQ-031 The iteration count (32) SHALL be a package constant.
REQ-032 The datapath SHALL consist of one 64-bit accumulator/remainder register, one 32-bit operand register, a 6-bit iteration counter, and sign flags.
REQ-033 Negation and absolute-value logic MAY be a single sub-module, md_abs32, instantiated for operand and result correction.

Verification
REQ-034 MUL, A=7, B=0xFFFFFFFD (-3) -> Y=0xFFFFFFEB; DONE exactly 33 cycles after the START edge; BUSY high for 33 cycles.
REQ-035 A=B=0xFFFFFFFF -> MULHU gives Y=0xFFFFFFFE, MULH gives Y=0x00000000, MULHSU gives Y=0xFFFFFFFF.
REQ-036 A=0xFFFFFFF9 (-7), B=2 -> DIV gives 0xFFFFFFFD, REM gives 0xFFFFFFFF, DIVU gives 0x7FFFFFFC, REMU gives 1.
REQ-037 Special cases: DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; each with 33-cycle latency.
REQ-038 START with different operands at cycle 5 of a busy MUL -> ignored, and the original result is returned.
REQ-039 RST at cycle 10 of a DIV -> no DONE pulse, BUSY=0 and Y=0; a MUL 3×4 started afterwards -> Y=12.
REQ-040 Back-to-back: START in the DONE cycle -> the second result arrives 33 cycles later, and the first Y holds until then.
